// File: rtl/pipe_control.sv
// ---------------------------------------------------------------------------
// pipe_control
//
// Purpose:
//   Decode stage control generator for a small in-order pipeline. Turns the
//   IF/ID opcode/funct7 into registered ID/EX control bits. It inserts
//   bubbles for hazard requests, for flushes and while a multi-cycle multiply
//   occupies EX. A two-state FSM with a 4-bit down-counter tracks the
//   multiply. Stall_out holds PC and IF/ID until the multiplier is free.
//
// Parameters:
//   MUL_LAT  EX-stage multiply latency in cycles (1..15)
//   JAL_EN   1: decode jal, 0: treat jal as illegal
//
// Ports:
//   clk_i         in   clock, rising edge
//   rst_i         in   asynchronous active-low reset
//   opcode_in     in   [6:0] opcode from IF/ID
//   funct7_in     in   [6:0] funct7 from IF/ID
//   NoOp_in       in   hazard-unit bubble request
//   Flush_in      in   branch/jump flush of the current decode
//   RegWrite_out .. Jump_out   out  registered ID/EX control bits
//   ALUOp_out     out  [1:0] registered ALU operation class
//   Mul_out       out  registered: issued instruction is a multiply
//   Illegal_out   out  registered: issued opcode was not decodable
//   Stall_out     out  combinational: hold PC and IF/ID this cycle
// ---------------------------------------------------------------------------
module pipe_control #(
    parameter int MUL_LAT = 3,
    parameter int JAL_EN  = 1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [6:0] opcode_in,
    input  logic [6:0] funct7_in,
    input  logic       NoOp_in,
    input  logic       Flush_in,
    output logic       RegWrite_out,
    output logic       MemtoReg_out,
    output logic       MemRead_out,
    output logic       MemWrite_out,
    output logic       ALUSrc_out,
    output logic       Branch_out,
    output logic       Jump_out,
    output logic [1:0] ALUOp_out,
    output logic       Mul_out,
    output logic       Illegal_out,
    output logic       Stall_out
);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_IALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] F7_MUL   = 7'b0000001;

    localparam logic [3:0] CNT_LOAD  = 4'(MUL_LAT - 1);
    localparam bit         MULTI_CYC = (MUL_LAT > 1);

    typedef enum logic {
        IDLE     = 1'b0,
        MUL_WAIT = 1'b1
    } state_t;

    state_t     state;
    logic [3:0] cnt;

    logic       regWriteNxt;
    logic       memtoRegNxt;
    logic       memReadNxt;
    logic       memWriteNxt;
    logic       aluSrcNxt;
    logic       branchNxt;
    logic       jumpNxt;
    logic [1:0] aluOpNxt;
    logic       mulNxt;
    logic       illegalNxt;
    logic       bubble;

    // The multiplier owns EX while waiting, so that source of bubbles wins.
    // Any bubble source also masks Illegal, because nothing is issued.
    assign bubble    = (state == MUL_WAIT) || Flush_in || NoOp_in;
    assign Stall_out = (state == MUL_WAIT);

    // ---- ID stage: combinational decode ----
    always_comb begin
        regWriteNxt = 1'b0;
        memtoRegNxt = 1'b0;
        memReadNxt  = 1'b0;
        memWriteNxt = 1'b0;
        aluSrcNxt   = 1'b0;
        branchNxt   = 1'b0;
        jumpNxt     = 1'b0;
        aluOpNxt    = 2'b00;
        mulNxt      = 1'b0;
        illegalNxt  = 1'b0;
        if (!bubble) begin
            case (opcode_in)
                OP_R: begin
                    regWriteNxt = 1'b1;
                    aluOpNxt    = 2'b10;
                    mulNxt      = (funct7_in == F7_MUL);
                end
                OP_IALU: begin
                    regWriteNxt = 1'b1;
                    aluOpNxt    = 2'b11;
                    aluSrcNxt   = 1'b1;
                end
                OP_LOAD: begin
                    regWriteNxt = 1'b1;
                    memtoRegNxt = 1'b1;
                    memReadNxt  = 1'b1;
                    aluSrcNxt   = 1'b1;
                end
                OP_STORE: begin
                    memWriteNxt = 1'b1;
                    aluSrcNxt   = 1'b1;
                end
                OP_BEQ: begin
                    branchNxt = 1'b1;
                    aluOpNxt  = 2'b01;
                end
                OP_JAL: begin
                    if (JAL_EN != 0) begin
                        regWriteNxt = 1'b1;
                        jumpNxt     = 1'b1;
                    end else begin
                        illegalNxt = 1'b1;
                    end
                end
                default: illegalNxt = 1'b1;
            endcase
        end
    end

    // ---- ID/EX boundary: registered control ----
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            RegWrite_out <= 1'b0;
            MemtoReg_out <= 1'b0;
            MemRead_out  <= 1'b0;
            MemWrite_out <= 1'b0;
            ALUSrc_out   <= 1'b0;
            Branch_out   <= 1'b0;
            Jump_out     <= 1'b0;
            ALUOp_out    <= 2'b00;
            Mul_out      <= 1'b0;
            Illegal_out  <= 1'b0;
        end else begin
            RegWrite_out <= regWriteNxt;
            MemtoReg_out <= memtoRegNxt;
            MemRead_out  <= memReadNxt;
            MemWrite_out <= memWriteNxt;
            ALUSrc_out   <= aluSrcNxt;
            Branch_out   <= branchNxt;
            Jump_out     <= jumpNxt;
            ALUOp_out    <= aluOpNxt;
            Mul_out      <= mulNxt;
            Illegal_out  <= illegalNxt;
        end
    end

    // ---- EX occupancy: multiply wait FSM ----
    // cnt counts the remaining busy cycles after the issue cycle. A
    // single-cycle multiplier never needs to stall the front end.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (mulNxt && MULTI_CYC) begin
                        state <= MUL_WAIT;
                        cnt   <= CNT_LOAD;
                    end
                end
                MUL_WAIT: begin
                    if (cnt == 4'd1) begin
                        state <= IDLE;
                        cnt   <= 4'd0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_control.sv
// ---------------------------------------------------------------------------
// tb_pipe_control
//
// Directed bench for pipe_control. dutA uses the defaults (MUL_LAT=3,
// JAL_EN=1). dutB (MUL_LAT=1, JAL_EN=0) shares the same inputs. Control
// outputs are packed as
//   {RegWrite, MemtoReg, MemRead, MemWrite, ALUSrc, Branch, Jump,
//    ALUOp[1:0], Mul, Illegal}
// and compared with hand-written constants.
// ---------------------------------------------------------------------------
module tb_pipe_control;

    localparam logic [10:0] V_BUB   = 11'b0000000_00_0_0;
    localparam logic [10:0] V_R     = 11'b1000000_10_0_0;
    localparam logic [10:0] V_MUL   = 11'b1000000_10_1_0;
    localparam logic [10:0] V_IALU  = 11'b1000100_11_0_0;
    localparam logic [10:0] V_LOAD  = 11'b1110100_00_0_0;
    localparam logic [10:0] V_STORE = 11'b0001100_00_0_0;
    localparam logic [10:0] V_BEQ   = 11'b0000010_01_0_0;
    localparam logic [10:0] V_JAL   = 11'b1000001_00_0_0;
    localparam logic [10:0] V_ILL   = 11'b0000000_00_0_1;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_IALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_BAD   = 7'b1111111;
    localparam logic [6:0] F7_MUL   = 7'b0000001;

    logic       clk = 1'b0;
    logic       rstN;
    logic [6:0] opcode;
    logic [6:0] funct7;
    logic       noOp;
    logic       flush;

    logic       aRegWrite, aMemtoReg, aMemRead, aMemWrite, aAluSrc, aBranch, aJump;
    logic [1:0] aAluOp;
    logic       aMul, aIllegal, aStall;
    logic       bRegWrite, bMemtoReg, bMemRead, bMemWrite, bAluSrc, bBranch, bJump;
    logic [1:0] bAluOp;
    logic       bMul, bIllegal, bStall;

    logic [10:0] ctrlA;
    logic [10:0] ctrlB;

    int passCnt  = 0;
    int totalCnt = 0;

    always #5 clk = ~clk;

    assign ctrlA = {aRegWrite, aMemtoReg, aMemRead, aMemWrite, aAluSrc, aBranch,
                    aJump, aAluOp, aMul, aIllegal};
    assign ctrlB = {bRegWrite, bMemtoReg, bMemRead, bMemWrite, bAluSrc, bBranch,
                    bJump, bAluOp, bMul, bIllegal};

    pipe_control #(.MUL_LAT(3), .JAL_EN(1)) dutA (
        .clk_i(clk), .rst_i(rstN), .opcode_in(opcode), .funct7_in(funct7),
        .NoOp_in(noOp), .Flush_in(flush),
        .RegWrite_out(aRegWrite), .MemtoReg_out(aMemtoReg), .MemRead_out(aMemRead),
        .MemWrite_out(aMemWrite), .ALUSrc_out(aAluSrc), .Branch_out(aBranch),
        .Jump_out(aJump), .ALUOp_out(aAluOp), .Mul_out(aMul),
        .Illegal_out(aIllegal), .Stall_out(aStall)
    );

    pipe_control #(.MUL_LAT(1), .JAL_EN(0)) dutB (
        .clk_i(clk), .rst_i(rstN), .opcode_in(opcode), .funct7_in(funct7),
        .NoOp_in(noOp), .Flush_in(flush),
        .RegWrite_out(bRegWrite), .MemtoReg_out(bMemtoReg), .MemRead_out(bMemRead),
        .MemWrite_out(bMemWrite), .ALUSrc_out(bAluSrc), .Branch_out(bBranch),
        .Jump_out(bJump), .ALUOp_out(bAluOp), .Mul_out(bMul),
        .Illegal_out(bIllegal), .Stall_out(bStall)
    );

    task automatic chk(input string tag, input logic [10:0] obs, input logic [10:0] exp);
        totalCnt++;
        assert (obs === exp) passCnt++;
        else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    endtask

    // Advance one rising edge; outputs are then sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setIn(input logic [6:0] op, input logic [6:0] f7,
                         input logic nop, input logic fl);
        opcode = op;
        funct7 = f7;
        noOp   = nop;
        flush  = fl;
    endtask

    initial begin
        // ---- reset with a load pending ----
        rstN = 1'b0;
        setIn(OP_LOAD, 7'd0, 1'b0, 1'b0);
        #3;
        chk("rst_ctrlA", ctrlA, V_BUB);
        chk("rst_stallA", {10'd0, aStall}, 11'd0);
        tick();
        tick();
        chk("rst_hold_ctrlA", ctrlA, V_BUB);
        rstN = 1'b1;
        tick();
        chk("post_rst_load", ctrlA, V_LOAD);

        // ---- decode sweep ----
        setIn(OP_R, 7'd0, 1'b0, 1'b0);     tick(); chk("dec_R", ctrlA, V_R);
        setIn(OP_IALU, 7'd0, 1'b0, 1'b0);  tick(); chk("dec_IALU", ctrlA, V_IALU);
        setIn(OP_LOAD, 7'd0, 1'b0, 1'b0);  tick(); chk("dec_LOAD", ctrlA, V_LOAD);
        setIn(OP_STORE, 7'd0, 1'b0, 1'b0); tick(); chk("dec_STORE", ctrlA, V_STORE);
        setIn(OP_BEQ, 7'd0, 1'b0, 1'b0);   tick(); chk("dec_BEQ", ctrlA, V_BEQ);
        setIn(OP_JAL, 7'd0, 1'b0, 1'b0);   tick(); chk("dec_JAL", ctrlA, V_JAL);
        chk("dec_JAL_disabled", ctrlB, V_ILL);
        setIn(OP_BAD, 7'd0, 1'b0, 1'b0);   tick(); chk("dec_BAD", ctrlA, V_ILL);
        chk("stall_idle", {10'd0, aStall}, 11'd0);

        // ---- single multiply, MUL_LAT=3, then I-ALU held by the stall ----
        setIn(OP_R, F7_MUL, 1'b0, 1'b0);
        tick();                                      // cycle 1
        chk("mul_c1_ctrl", ctrlA, V_MUL);
        chk("mul_c1_stall", {10'd0, aStall}, 11'd1);
        chk("mul1_c1_stallB", {10'd0, bStall}, 11'd0);
        chk("mul1_c1_ctrlB", ctrlB, V_MUL);
        setIn(OP_IALU, 7'd0, 1'b0, 1'b0);
        tick();                                      // cycle 2
        chk("mul_c2_ctrl", ctrlA, V_BUB);
        chk("mul_c2_stall", {10'd0, aStall}, 11'd1);
        tick();                                      // cycle 3
        chk("mul_c3_ctrl", ctrlA, V_BUB);
        chk("mul_c3_stall", {10'd0, aStall}, 11'd0);
        tick();                                      // cycle 4
        chk("mul_c4_next", ctrlA, V_IALU);

        // ---- back-to-back multiplies issue MUL_LAT cycles apart ----
        setIn(OP_R, F7_MUL, 1'b0, 1'b0);
        tick();                                      // cycle 1: first issue
        chk("b2b_c1", ctrlA, V_MUL);
        chk("b2b_c1_B", ctrlB, V_MUL);
        tick();                                      // cycle 2
        chk("b2b_c2", ctrlA, V_BUB);
        chk("b2b_c2_B", ctrlB, V_MUL);
        chk("b2b_c2_stallB", {10'd0, bStall}, 11'd0);
        tick();                                      // cycle 3
        chk("b2b_c3", ctrlA, V_BUB);
        chk("b2b_c3_stallB", {10'd0, bStall}, 11'd0);
        tick();                                      // cycle 4: second issue
        chk("b2b_c4", ctrlA, V_MUL);
        chk("b2b_c4_stall", {10'd0, aStall}, 11'd1);

        // ---- flush during MUL_WAIT leaves the wait untouched ----
        setIn(OP_R, F7_MUL, 1'b0, 1'b1);
        #1;
        chk("wait_flush_stall_now", {10'd0, aStall}, 11'd1);
        tick();                                      // cnt 1, still waiting
        chk("wait_flush_stall", {10'd0, aStall}, 11'd1);
        chk("wait_flush_ctrl", ctrlA, V_BUB);
        setIn(OP_R, F7_MUL, 1'b0, 1'b0);
        tick();                                      // back to IDLE on schedule
        chk("wait_exit_stall", {10'd0, aStall}, 11'd0);
        tick();                                      // third multiply issued
        chk("mul3_issue", ctrlA, V_MUL);
        chk("mul3_stall", {10'd0, aStall}, 11'd1);

        // ---- reset in the middle of MUL_WAIT aborts at once ----
        rstN = 1'b0;
        #1;
        chk("midwait_rst_stall", {10'd0, aStall}, 11'd0);
        chk("midwait_rst_ctrl", ctrlA, V_BUB);
        setIn(OP_STORE, 7'd0, 1'b0, 1'b0);
        tick();
        rstN = 1'b1;
        tick();
        chk("post_midwait_rst", ctrlA, V_STORE);

        // ---- flush / no-op bubbles suppress Illegal ----
        setIn(OP_BEQ, 7'd0, 1'b0, 1'b1);   tick(); chk("flush_beq", ctrlA, V_BUB);
        setIn(OP_BAD, 7'd0, 1'b1, 1'b0);   tick(); chk("noop_bad", ctrlA, V_BUB);
        setIn(OP_R, F7_MUL, 1'b1, 1'b0);   tick(); chk("noop_mul", ctrlA, V_BUB);
        chk("noop_mul_stall", {10'd0, aStall}, 11'd0);
        setIn(OP_R, 7'd0, 1'b0, 1'b0);     tick(); chk("plain_R", ctrlA, V_R);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
